// File: rtl/dbg_cmd_pkg.sv
// Shared defaults and state encoding for the debug-command system-clock FIFO.
package dbg_cmd_pkg;

  localparam int DEF_DATA_W      = 38;
  localparam int DEF_IR_W        = 2;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dbg_cmd_fifo.sv
// Command FIFO whose head word and valid flag are registered, so the head is a
// flop view of the oldest entry rather than an extra storage slot.
module dbg_cmd_fifo
  import dbg_cmd_pkg::*;
#(
  parameter int W     = DEF_DATA_W + DEF_IR_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [W-1:0]              wdata,
  input  logic                      pop,
  output logic                      head_valid,
  output logic [W-1:0]              head_data,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_inc;
  logic [LW-1:0] level_d;
  logic [W-1:0]  head_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_inc  = rd_ptr + AW'(1);

  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    level_d = level;
    head_d  = head_data;
    case ({do_push, do_pop})
      2'b10:   level_d = level + LW'(1);
      2'b01:   level_d = level - LW'(1);
      default: ;
    endcase
    // The next head is the entry behind the current one, or the incoming word
    // when that entry does not exist yet.
    if (do_pop) begin
      if (level > LW'(1)) head_d = mem[rd_inc];
      else if (do_push)   head_d = wdata;
    end else if (empty && do_push) begin
      head_d = wdata;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
      // NOTE: storage is cleared on reset so no stale command survives it.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_inc;
      level      <= level_d;
      head_valid <= (level_d != '0);
      head_data  <= head_d;
    end
  end

endmodule

// File: rtl/dbg_cmd_sysclk_fifo.sv
// JTAG update-DR commands moved into the system clock domain and queued.
// Optional odd-parity checking is enabled with the DBG_CMD_PARITY_EN macro.
module dbg_cmd_sysclk_fifo
  import dbg_cmd_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IR_W        = DEF_IR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      udr_tgl,
  input  logic [IR_W-1:0]           ir_in,
  input  logic [DATA_W-1:0]         sr,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [IR_W-1:0]           cmd_ir,
  output logic [DATA_W-1:0]         cmd_data,
  output logic [2**IR_W-1:0]        take_action,
  output logic [2**IR_W-1:0]        take_no_action,
  output logic [lvl_w(DEPTH)-1:0]   fifo_level,
  output logic                      overflow,
  input  logic                      clr_ovf
`ifdef DBG_CMD_PARITY_EN
  ,
  output logic [7:0]                parity_err_cnt
`endif
);

  localparam int NCH = 2**IR_W;
  localparam int W   = IR_W + DATA_W;
  localparam int CW  = $clog2(SYNC_STAGES + 2);

  state_t                 state;
  logic [CW-1:0]          warm_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   edge_ref;
  logic                   push_q;
  logic [W-1:0]           push_word;
  logic [W-1:0]           head_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   ovf_set;
  logic                   parity_ok;
  logic [NCH-1:0]         head_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], udr_tgl};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef DBG_CMD_PARITY_EN
  assign parity_ok = ^{ir_in, sr};
`else
  assign parity_ok = 1'b1;
`endif

  // The edge reference follows the synchroniser during warm-up, so a toggle
  // level present at reset release never turns into a command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WARMUP;
      warm_cnt  <= '0;
      edge_ref  <= 1'b0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      edge_ref <= sync_out;
      push_q   <= 1'b0;
      case (state)
        WARMUP: begin
          if (warm_cnt == CW'(SYNC_STAGES)) state <= RUN;
          else                              warm_cnt <= warm_cnt + CW'(1);
        end
        RUN: begin
          if (sync_out != edge_ref) begin
            push_q    <= parity_ok;
            push_word <= {ir_in, sr};
          end
        end
        default: state <= WARMUP;
      endcase
    end
  end

`ifdef DBG_CMD_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err_cnt <= '0;
    end else if (state == RUN && sync_out != edge_ref && !parity_ok &&
                 parity_err_cnt != 8'hFF) begin
      parity_err_cnt <= parity_err_cnt + 8'd1;
    end
  end
`endif

  dbg_cmd_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_q),
    .wdata      (push_word),
    .pop        (pop),
    .head_valid (cmd_valid),
    .head_data  (head_data),
    .level      (fifo_level),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign {cmd_ir, cmd_data} = head_data;
  assign pop      = cmd_valid && cmd_ready && !fifo_empty;
  assign ovf_set  = push_q && fifo_full && !pop;
  assign head_sel = NCH'(1) << cmd_ir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= (pop &&  cmd_data[DATA_W-1]) ? head_sel : '0;
      take_no_action <= (pop && !cmd_data[DATA_W-1]) ? head_sel : '0;
    end
  end

endmodule

// File: tb/tb_dbg_cmd_sysclk_fifo.sv
// Directed bench for dbg_cmd_sysclk_fifo with hand-computed expectations.
module tb_dbg_cmd_sysclk_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        udr_tgl;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        clr_ovf;
`ifdef DBG_CMD_PARITY_EN
  logic [7:0]  parity_err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dbg_cmd_sysclk_fifo dut (
    .clk            (clk),
    .reset          (reset),
    .udr_tgl        (udr_tgl),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_ir         (cmd_ir),
    .cmd_data       (cmd_data),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .clr_ovf        (clr_ovf)
`ifdef DBG_CMD_PARITY_EN
    ,
    .parity_err_cnt (parity_err_cnt)
`endif
  );

  // Sets sr[36] so the word has odd parity; harmless when parity is off.
  function automatic logic [37:0] mk(input logic [1:0] ir, input logic [37:0] d);
    logic [37:0] r;
    r     = d;
    r[36] = ~(^{ir, d[37], d[35:0]});
    return r;
  endfunction

  task automatic send(input logic [1:0] ir, input logic [37:0] d);
    @(posedge clk); #1;
    ir_in   = ir;
    sr      = d;
    udr_tgl = ~udr_tgl;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got=%b exp=0", cmd_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got=%0d exp=0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got=%b exp=0", overflow); end
    checks++; if ({cmd_ir, cmd_data} !== 40'd0) begin errors++; $display("FAIL reset_head: got=%h exp=0", {cmd_ir, cmd_data}); end
    checks++; if ({take_action, take_no_action} !== 8'd0) begin errors++; $display("FAIL reset_pulses: got=%b exp=0", {take_action, take_no_action}); end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL reset_release: valid=%b level=%0d exp 0/0", cmd_valid, fifo_level); end
  endtask

  task automatic test_single_cmd;
    logic [37:0] d;
    d = mk(2'b01, {1'b1, 37'h1234});
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    ir_in = 2'b01; sr = d; udr_tgl = ~udr_tgl;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL single_early_e%0d: valid=%b exp=0", e, cmd_valid); end
    end
    @(posedge clk); #1;
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL single_valid_e4: got=%b exp=1", cmd_valid); end
    checks++; if (cmd_ir !== 2'b01 || cmd_data !== d) begin errors++; $display("FAIL single_head: got=%b/%h exp=01/%h", cmd_ir, cmd_data, d); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level: got=%0d exp=1", fifo_level); end
    @(posedge clk); #1;
    checks++; if (take_action !== 4'b0010 || take_no_action !== 4'b0000) begin errors++; $display("FAIL single_pulse: ta=%b tna=%b exp 0010/0000", take_action, take_no_action); end
    checks++; if (cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL single_popped: valid=%b level=%0d exp 0/0", cmd_valid, fifo_level); end
    @(posedge clk); #1;
    checks++; if (take_action !== 4'b0000) begin errors++; $display("FAIL single_pulse_len: ta=%b exp=0000", take_action); end
  endtask

  task automatic test_no_action;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    ir_in = 2'b11; sr = mk(2'b11, {1'b0, 37'h5A5A}); udr_tgl = ~udr_tgl;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (take_no_action !== 4'b1000 || take_action !== 4'b0000) begin errors++; $display("FAIL noact_pulse: ta=%b tna=%b exp 0000/1000", take_action, take_no_action); end
    @(posedge clk); #1;
    checks++; if (take_no_action !== 4'b0000) begin errors++; $display("FAIL noact_pulse_len: tna=%b exp=0000", take_no_action); end
    cmd_ready = 1'b0;
  endtask

  task automatic test_overflow;
    logic [1:0]  ir_v [5];
    logic [37:0] d_v  [5];
    logic [3:0]  exp_ta;
    logic [3:0]  exp_tna;
    ir_v = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    for (int i = 0; i < 5; i++) d_v[i] = mk(ir_v[i], {(i % 2 == 0), 37'(100 + i)});
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(ir_v[i], d_v[i]);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got=%0d exp=4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got=%b exp=1", overflow); end
    for (int i = 0; i < 4; i++) begin
      exp_ta  = d_v[i][37] ? (4'b0001 << ir_v[i]) : 4'b0000;
      exp_tna = d_v[i][37] ? 4'b0000 : (4'b0001 << ir_v[i]);
      checks++; if (cmd_valid !== 1'b1 || cmd_ir !== ir_v[i] || cmd_data !== d_v[i]) begin errors++; $display("FAIL ovf_head%0d: got=%b/%b/%h exp=1/%b/%h", i, cmd_valid, cmd_ir, cmd_data, ir_v[i], d_v[i]); end
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      checks++; if (take_action !== exp_ta || take_no_action !== exp_tna) begin errors++; $display("FAIL ovf_pulse%0d: ta=%b tna=%b exp %b/%b", i, take_action, take_no_action, exp_ta, exp_tna); end
    end
    checks++; if (cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_fifth_absent: valid=%b level=%0d exp 0/0", cmd_valid, fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got=%b exp=1", overflow); end
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop;
    logic [1:0]  ir_v [5];
    logic [37:0] d_v  [5];
    ir_v = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd2};
    for (int i = 0; i < 5; i++) d_v[i] = mk(ir_v[i], {(i % 2 == 1), 37'(200 + i)});
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(ir_v[i], d_v[i]);
    @(posedge clk); #1;
    ir_in = ir_v[4]; sr = d_v[4]; udr_tgl = ~udr_tgl;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fpp_pre_level: got=%0d exp=4", fifo_level); end
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    checks++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_level_ovf: level=%0d ovf=%b exp 4/0", fifo_level, overflow); end
    checks++; if (take_action !== 4'b0000 || take_no_action !== 4'b1000) begin errors++; $display("FAIL fpp_pulse: ta=%b tna=%b exp 0000/1000", take_action, take_no_action); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (cmd_valid !== 1'b1 || cmd_ir !== ir_v[i] || cmd_data !== d_v[i]) begin errors++; $display("FAIL fpp_head%0d: got=%b/%b/%h exp=1/%b/%h", i, cmd_valid, cmd_ir, cmd_data, ir_v[i], d_v[i]); end
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;
    end
    checks++; if (fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin errors++; $display("FAIL fpp_drained: level=%0d valid=%b exp 0/0", fifo_level, cmd_valid); end
  endtask

  task automatic test_clr_ovf;
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'(i), mk(2'(i), {1'b1, 37'(300 + i)}));
    @(posedge clk); #1;
    ir_in = 2'd0; sr = mk(2'd0, {1'b0, 37'h3FF}); udr_tgl = ~udr_tgl;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_pre: got=%b exp=0", overflow); end
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b1 || fifo_level !== 3'd4) begin errors++; $display("FAIL clr_set_wins: ovf=%b level=%0d exp 1/4", overflow, fifo_level); end
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_lone: got=%b exp=0", overflow); end
    cmd_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    cmd_ready = 1'b0;
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL clr_drain: level=%0d exp=0", fifo_level); end
  endtask

  task automatic test_reset_midflight;
    logic        bad;
    logic [37:0] d;
    cmd_ready = 1'b0;
    send(2'd1, mk(2'd1, {1'b1, 37'h41}));
    send(2'd2, mk(2'd2, {1'b1, 37'h42}));
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL mid_queued: level=%0d exp=2", fifo_level); end
    @(posedge clk); #1;
    udr_tgl = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL mid_reset: valid=%b level=%0d exp 0/0", cmd_valid, fifo_level); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmd_ready = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (cmd_valid !== 1'b0 || fifo_level !== 3'd0 || take_action !== 4'd0 || take_no_action !== 4'd0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mid_no_push: spurious activity=%b exp=0", bad); end
    d = mk(2'd3, {1'b1, 37'h77});
    ir_in = 2'd3; sr = d; udr_tgl = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (cmd_valid !== 1'b1 || cmd_data !== d) begin errors++; $display("FAIL mid_recover: valid=%b data=%h exp 1/%h", cmd_valid, cmd_data, d); end
    @(posedge clk); #1;
    checks++; if (take_action !== 4'b1000) begin errors++; $display("FAIL mid_recover_pulse: ta=%b exp=1000", take_action); end
    cmd_ready = 1'b0;
  endtask

`ifdef DBG_CMD_PARITY_EN
  task automatic test_parity;
    cmd_ready = 1'b0;
    send(2'd0, 38'd0);
    checks++; if (fifo_level !== 3'd0 || parity_err_cnt !== 8'd1) begin errors++; $display("FAIL par_bad: level=%0d cnt=%0d exp 0/1", fifo_level, parity_err_cnt); end
    send(2'd0, mk(2'd0, 38'd1));
    checks++; if (fifo_level !== 3'd1 || parity_err_cnt !== 8'd1) begin errors++; $display("FAIL par_good: level=%0d cnt=%0d exp 1/1", fifo_level, parity_err_cnt); end
    for (int i = 0; i < 255; i++) send(2'd0, 38'd0);
    checks++; if (parity_err_cnt !== 8'd255 || fifo_level !== 3'd1) begin errors++; $display("FAIL par_saturate: cnt=%0d level=%0d exp 255/1", parity_err_cnt, fifo_level); end
  endtask
`endif

  initial begin
    reset     = 1'b0;
    udr_tgl   = 1'b0;
    ir_in     = 2'd0;
    sr        = '0;
    cmd_ready = 1'b0;
    clr_ovf   = 1'b0;
    test_reset;
    test_single_cmd;
    test_no_action;
    test_overflow;
    test_full_push_pop;
    test_clr_ovf;
    test_reset_midflight;
`ifdef DBG_CMD_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbg_cmd_sysclk_fifo.md
DBG_CMD_SYSCLK_FIFO -- requirements
Module: dbg_cmd_sysclk_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 38: width of debug data word (sr/cmd_data).
REQ-002 SHALL have parameter IR_W, default 2: width of instruction register; 2**IR_W command channels.
REQ-003 SHALL have parameter DEPTH, default 4: command FIFO entries, power of two, >=2.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops on udr_tgl, >=2.
REQ-005 SHALL have port clk  in  1: single system clock; all state on its rising edge.
REQ-006 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-007 SHALL have port udr_tgl  in  1: asynchronous; toggles once per JTAG update-DR.
REQ-008 SHALL have port ir_in  in  IR_W: instruction; stable >= SYNC_STAGES+3 clk after each udr_tgl change.
REQ-009 SHALL have port sr  in  DATA_W: shifted data; same stability as ir_in.
REQ-010 SHALL have port cmd_valid  out  1: FIFO head valid.
REQ-011 SHALL have port cmd_ready  in  1: consumer accepts head when high with cmd_valid.
REQ-012 SHALL have port cmd_ir  out  IR_W and cmd_data  out  DATA_W: FIFO head contents.
REQ-013 SHALL have port take_action  out  2**IR_W and take_no_action  out  2**IR_W: one-hot pop pulses.
REQ-014 SHALL have port fifo_level  out  $clog2(DEPTH)+1: current occupancy.
REQ-015 SHALL have port overflow  out  1 (sticky) and clr_ovf  in  1 (synchronous clear).

Function
REQ-016 SHALL detect any udr_tgl change after the synchroniser and push {ir_in, sr} into the FIFO as one entry.
REQ-017 SHALL, for SYNC_STAGES=2 and empty FIFO, assert cmd_valid on the 4th rising clk edge counting the first edge that samples a new udr_tgl value (SYNC_STAGES+2 generally).
REQ-018 SHALL pop the head on any cycle with cmd_valid && cmd_ready; cmd_valid/cmd_ir/cmd_data registered, stable while cmd_valid && !cmd_ready.
REQ-019 SHALL pulse take_action[cmd_ir] for one cycle, the cycle after a pop, when popped cmd_data[DATA_W-1]=1; else take_no_action[cmd_ir]; all other bits 0.
REQ-020 SHALL, on push with FIFO full and no same-cycle pop, drop the entry, keep contents, and set overflow.
REQ-021 SHALL, on simultaneous push and pop (including full), accept both; fifo_level unchanged.
REQ-022 SHALL let set win when overflow-set and clr_ovf coincide.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; fifo_level counts 0..DEPTH inclusive.
REQ-024 SHALL run a warm-up FSM: WARMUP (SYNC_STAGES+1 cycles, edge reference tracks synchronised udr_tgl, no pushes) -> RUN; RUN is absorbing until reset.

Reset
REQ-025 SHALL, on reset assertion, immediately clear FIFO, pointers, synchroniser, edge reference, overflow, pulses, fifo_level; cmd_valid=0, cmd_ir=0, cmd_data=0; FSM=WARMUP.
REQ-026 SHALL not generate a push from a udr_tgl level already high when reset deasserts.
REQ-027 SHALL discard, on reset mid-transfer, any in-flight or queued command without pulsing take_*.

Configuration
REQ-028 SHALL, with DBG_CMD_PARITY_EN defined, treat sr[DATA_W-2] as odd parity over {ir_in, sr without that bit}, drop mismatching commands, and increment output parity_err_cnt (8 bits, saturating, reset 0).
REQ-029 SHALL, without DBG_CMD_PARITY_EN, push all commands unchecked and omit parity_err_cnt port.

Structure
REQ-030 SHALL place default widths, DEPTH, and the FSM state enum (WARMUP, RUN) in shared package dbg_cmd_pkg.
REQ-031 SHALL instantiate one sub-module dbg_cmd_fifo (parametrised DATA_W+IR_W wide, DEPTH deep, level/full/empty outputs).

Verification
REQ-032 SHALL cover single command: ir_in=2'b01, sr MSB=1, toggle udr_tgl, cmd_ready=1 -> cmd_valid at edge 4, take_action=4'b0010 one cycle.
REQ-033 SHALL cover overflow: 5 toggles, cmd_ready=0, DEPTH=4 -> fifo_level=4, overflow=1, heads 1..4 popped in order, 5th absent.
REQ-034 SHALL cover full push+pop same cycle: level stays 4, overflow stays 0.
REQ-035 SHALL cover reset with udr_tgl=1 and 2 queued -> cmd_valid=0, level=0, no push after deassertion.
REQ-036 SHALL cover clr_ovf coinciding with overflow event -> overflow=1; next lone clr_ovf -> 0.
REQ-037 SHALL cover DBG_CMD_PARITY_EN with bad parity -> no push, parity_err_cnt 0->1; 256 errors -> saturates at 255.
